// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: sequences JAL/JALR target and link resolution, link write, flush and fetch redirect
module jump_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_jal,
    input  logic            req_jalr,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic [4:0]      req_rd,
    input  logic            rs1_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            kill,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            flush_o,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_tval,
    output logic            illegal_o
);
    typedef enum logic [1:0] {IDLE, WAIT_RS1, FLUSH, REDIRECT} state_t;
    state_t          state;
    logic [XLEN-1:0] target, link, imm_q;
    logic [4:0]      rd;
    logic [3:0]      cnt;
    logic [XLEN-1:0] jalr_tgt, new_tgt, new_link;
    logic [4:0]      new_rd;
    logic            go_flush;

    // target/link of a jump that resolves this cycle, from the live request in IDLE or the latched one in WAIT_RS1
    always_comb begin
        jalr_tgt = (rs1_data + (state == IDLE ? req_imm : imm_q)) & ~XLEN'(1);
        new_tgt  = (state == IDLE && !req_jalr) ? req_pc + req_imm : jalr_tgt;
        new_link = state == IDLE ? req_pc + XLEN'(4) : link;
        new_rd   = state == IDLE ? req_rd : rd;
        go_flush = (state == IDLE && req_valid && (req_jalr ? rs1_ready : req_jal)) ||
                   (state == WAIT_RS1 && rs1_ready);
    end

    // sequencing FSM with registered handshake, flush, link-write and exception outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rd_we         <= 1'b0;
            rd_addr       <= '0;
            rd_data       <= '0;
            flush_o       <= 1'b0;
            redir_valid   <= 1'b0;
            redir_pc      <= '0;
            misalign_o    <= 1'b0;
            misalign_tval <= '0;
            illegal_o     <= 1'b0;
            target        <= '0;
            link          <= '0;
            imm_q         <= '0;
            rd            <= '0;
            cnt           <= '0;
        end else if (kill) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rd_we       <= 1'b0;
            flush_o     <= 1'b0;
            redir_valid <= 1'b0;
            misalign_o  <= 1'b0;
            illegal_o   <= 1'b0;
            cnt         <= '0;
        end else begin
            rd_we      <= 1'b0;
            misalign_o <= 1'b0;
            illegal_o  <= 1'b0;
            if (go_flush) begin
                state         <= FLUSH;
                req_ready     <= 1'b0;
                flush_o       <= 1'b1;
                cnt           <= 4'(FLUSH_CYCLES - 1);
                target        <= new_tgt;
                link          <= new_link;
                rd            <= new_rd;
                rd_we         <= (new_rd != 5'd0) && !new_tgt[1];
                rd_addr       <= new_rd;
                rd_data       <= new_link;
                misalign_o    <= new_tgt[1];
                misalign_tval <= new_tgt;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_jalr) begin
                            state     <= WAIT_RS1;
                            req_ready <= 1'b0;
                            imm_q     <= req_imm;
                            link      <= req_pc + XLEN'(4);
                            rd        <= req_rd;
                        end else if (req_valid) begin
                            illegal_o <= 1'b1;
                        end
                    end
                    WAIT_RS1: begin
                        state <= WAIT_RS1;
                    end
                    FLUSH: begin
                        if (cnt == 4'd0) begin
                            flush_o     <= 1'b0;
                            state       <= target[1] ? IDLE : REDIRECT;
                            req_ready   <= target[1];
                            redir_valid <= !target[1];
                            redir_pc    <= target;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    REDIRECT: begin
                        if (redir_ready) begin
                            state       <= IDLE;
                            redir_valid <= 1'b0;
                            req_ready   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// tb_jump_redirect_ctrl: vector table plus kill/reset sequences, scoreboard of rd/misalign/illegal/redirect events
module tb_jump_redirect_ctrl;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0, req_jal = 1'b0, req_jalr = 1'b0;
    logic [XLEN-1:0] req_pc = '0, req_imm = '0, rs1_data = '0;
    logic [4:0]      req_rd = '0;
    logic            rs1_ready = 1'b0, kill = 1'b0, redir_ready = 1'b0;
    logic            req_ready, rd_we, flush_o, redir_valid, misalign_o, illegal_o;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data, redir_pc, misalign_tval;
    int              n_checks = 0;
    int              n_fail = 0;

    typedef enum logic [1:0] {EV_WE, EV_MIS, EV_REDIR, EV_ILL} ev_kind_t;
    typedef struct packed {
        ev_kind_t        kind;
        logic [XLEN-1:0] val;
        logic [4:0]      addr;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic            jal, jalr;
        logic [XLEN-1:0] pc, imm, rs1;
        logic [4:0]      rd;
        int              stall, bp;
        logic [XLEN-1:0] tgt, link;
        logic            we, mis, ill;
    } vec_t;
    vec_t vecs[$];

    jump_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_jal(req_jal), .req_jalr(req_jalr), .req_pc(req_pc), .req_imm(req_imm),
        .req_rd(req_rd), .rs1_ready(rs1_ready), .rs1_data(rs1_data), .kill(kill),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .flush_o(flush_o),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .misalign_o(misalign_o), .misalign_tval(misalign_tval), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [XLEN-1:0] v, input logic [4:0] a);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.addr = a;
        sb.push_back(e);
    endtask

    task automatic got_ev(input ev_kind_t k, input logic [XLEN-1:0] v, input logic [4:0] a);
        ev_t e;
        chk($sformatf("sb_event_expected kind%0d", k), 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_event", {k, v, a}, {e.kind, e.val, e.addr});
        end
    endtask

    // advance one cycle; inputs for this cycle are already driven, outputs sampled at the following negedge
    task automatic step();
        if (rst_n && redir_valid && redir_ready) got_ev(EV_REDIR, redir_pc, 5'd0);
        @(negedge clk);
        if (rst_n) begin
            if (rd_we) got_ev(EV_WE, rd_data, rd_addr);
            if (misalign_o) got_ev(EV_MIS, misalign_tval, 5'd0);
            if (illegal_o) got_ev(EV_ILL, '0, 5'd0);
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (!req_ready && i < 60) begin
            step();
            i++;
        end
        chk("idle_reached", 64'(req_ready), 64'd1);
    endtask

    function automatic vec_t mk(input logic jal, input logic jalr, input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                                input logic [4:0] rd, input int stall, input int bp,
                                input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] link,
                                input logic we, input logic mis, input logic ill);
        vec_t v;
        v.jal = jal; v.jalr = jalr; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rd = rd;
        v.stall = stall; v.bp = bp; v.tgt = tgt; v.link = link; v.we = we; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int s, r, fin, bad, fc;
        logic [37:0] a_v, e_v, fa, fe;
        logic pc_on;
        wait_idle();
        s = v.jalr ? v.stall : 0;
        r = s + FC + 1;
        fin = v.ill ? 1 : (v.mis ? s + FC + 1 : r + v.bp + 1);
        bad = 0;
        fc = 0;
        fa = '0;
        fe = '0;
        if (v.ill) push_ev(EV_ILL, '0, 5'd0);
        else if (v.mis) push_ev(EV_MIS, v.tgt, 5'd0);
        else begin
            if (v.we) push_ev(EV_WE, v.link, v.rd);
            push_ev(EV_REDIR, v.tgt, 5'd0);
        end
        for (int c = 0; c <= fin + 1; c++) begin
            if (c > 0) step();
            pc_on = !v.ill && !v.mis && c >= r && c <= r + v.bp;
            a_v = {req_ready, flush_o, rd_we, redir_valid, misalign_o, illegal_o,
                   redir_valid ? redir_pc : {XLEN{1'b0}}};
            e_v = {c == 0 || c >= fin, !v.ill && c >= s + 1 && c <= s + FC, v.we && c == s + 1,
                   pc_on, v.mis && c == s + 1, v.ill && c == 1, pc_on ? v.tgt : {XLEN{1'b0}}};
            if (bad == 0) begin
                fa = a_v;
                fe = e_v;
                fc = c;
            end
            if (a_v !== e_v) bad++;
            req_valid   = c == 0;
            req_jal     = v.jal;
            req_jalr    = v.jalr;
            req_pc      = c == 0 ? v.pc : ~v.pc;
            req_imm     = c == 0 ? v.imm : ~v.imm;
            req_rd      = c == 0 ? v.rd : ~v.rd;
            rs1_ready   = c >= s;
            rs1_data    = c >= s ? v.rs1 : 32'hDEAD_BEE1;
            redir_ready = v.bp == 0 || c >= r + v.bp;
        end
        chk($sformatf("vec%0d ctrl/pc at cycle %0d", idx, fc), 64'(fa), 64'(fe));
        chk($sformatf("vec%0d sb_drained", idx), 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs.push_back(mk(1, 0, 32'h100, 32'h20, 32'h0, 5'd1, 0, 0, 32'h120, 32'h104, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h40, 32'h4, 32'h2001, 5'd2, 3, 0, 32'h2004, 32'h44, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80, 32'h2, 32'h1000, 5'd5, 0, 0, 32'h1002, 32'h84, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h200, 32'h10, 32'h0, 5'd0, 0, 4, 32'h210, 32'h204, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd3, 0, 0, 32'h4, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h300, 32'h100, 32'h5000, 5'd7, 1, 0, 32'h5100, 32'h304, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h400, 32'h0, 32'h0, 5'd9, 0, 0, 32'h0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h1000, 32'hFFFF_FFF0, 32'h0, 5'd31, 0, 2, 32'hFF0, 32'h1004, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 32'h6, 32'h0, 5'd4, 0, 0, 32'h106, 32'h104, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h500, 32'h0, 32'h3005, 5'd6, 0, 1, 32'h3004, 32'h504, 1, 0, 0));

        step();
        step();
        chk("reset_ctrl", 64'({req_ready, rd_we, flush_o, redir_valid, misalign_o, illegal_o}), 64'b100000);
        chk("reset_rd", 64'({rd_addr, rd_data}), 64'd0);
        chk("reset_pc", {redir_pc, misalign_tval}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // kill while waiting on rs1: nothing may follow, even though rs1 becomes ready that cycle
        wait_idle();
        req_valid = 1'b1; req_jal = 1'b0; req_jalr = 1'b1; req_pc = 32'h600; req_imm = 32'h10;
        req_rd = 5'd8; rs1_ready = 1'b0; redir_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("k1_req_ready_low_in_wait", 64'(req_ready), 64'd0);
        step();
        kill = 1'b1; rs1_ready = 1'b1; rs1_data = 32'h7000;
        step();
        kill = 1'b0;
        chk("k1_idle_after_kill", 64'({req_ready, flush_o, rd_we}), 64'b100);
        repeat (4) step();
        chk("k1_quiet", 64'({flush_o, redir_valid, sb.size() != 0}), 64'd0);
        run_vec(100, vecs[0]);

        // kill while a redirect is pending and fetch has not accepted it
        wait_idle();
        push_ev(EV_WE, 32'h704, 5'd4);
        req_valid = 1'b1; req_jal = 1'b1; req_jalr = 1'b0; req_pc = 32'h700; req_imm = 32'h40;
        req_rd = 5'd4; redir_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !redir_valid; i++) step();
        chk("k2_redir_seen", {redir_valid, redir_pc}, {1'b1, 32'h740});
        kill = 1'b1;
        step();
        kill = 1'b0;
        redir_ready = 1'b1;
        chk("k2_idle_after_kill", 64'({redir_valid, flush_o, req_ready}), 64'b001);
        repeat (3) step();
        chk("k2_sb_drained", 64'(sb.size()), 64'd0);
        run_vec(101, vecs[3]);

        // kill in IDLE blocks a request presented the same cycle
        wait_idle();
        req_valid = 1'b1; req_jal = 1'b1; req_jalr = 1'b0; req_pc = 32'h900; req_imm = 32'h8;
        req_rd = 5'd11; kill = 1'b1;
        step();
        req_valid = 1'b0; kill = 1'b0;
        chk("k3_not_accepted", 64'({req_ready, flush_o, rd_we}), 64'b100);
        step();
        chk("k3_quiet", 64'({flush_o, redir_valid, sb.size() != 0}), 64'd0);

        // asynchronous reset in the middle of a flush
        wait_idle();
        push_ev(EV_WE, 32'h804, 5'd10);
        req_valid = 1'b1; req_jal = 1'b1; req_jalr = 1'b0; req_pc = 32'h800; req_imm = 32'h8;
        req_rd = 5'd10;
        step();
        req_valid = 1'b0;
        chk("rst_mid_flushing", 64'(flush_o), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_async_clear", 64'({req_ready, flush_o, rd_we, redir_valid}), 64'b1000);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("rst_mid_no_redirect", 64'({redir_valid, sb.size() != 0}), 64'd0);
        run_vec(102, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
